// File: rtl/nec_ir_tx.sv
// NEC infrared frame generator: leader, 32 LSB-first data bits, stop burst, then
// repeat codes every T_PERIOD cycles while hold stays asserted at each period end.
module nec_ir_tx #(
    parameter int T_LEAD_L    = 450000,
    parameter int T_LEAD_H    = 225000,
    parameter int T_REP_H     = 112500,
    parameter int T_MARK      = 28000,
    parameter int T_ONE_H     = 84500,
    parameter int T_ZERO_H    = 28000,
    parameter int T_PERIOD    = 5500000,
    parameter int CARRIER_DIV = 1316
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    input  logic       hold,
    output logic       busy,
    output logic       done,
    output logic       ir_out,
    output logic       ir_led
);

    typedef enum logic [3:0] {
        IDLE,
        LEAD_L,
        LEAD_H,
        BIT_L,
        BIT_H,
        STOP_L,
        GAP,
        REP_L,
        REP_H,
        REP_STOP
    } state_t;

    localparam logic [22:0] D_LEAD_L = 23'(T_LEAD_L - 1);
    localparam logic [22:0] D_LEAD_H = 23'(T_LEAD_H - 1);
    localparam logic [22:0] D_REP_H  = 23'(T_REP_H - 1);
    localparam logic [22:0] D_MARK   = 23'(T_MARK - 1);
    localparam logic [22:0] D_ONE_H  = 23'(T_ONE_H - 1);
    localparam logic [22:0] D_ZERO_H = 23'(T_ZERO_H - 1);
    localparam logic [22:0] P_LAST   = 23'(T_PERIOD - 1);
    localparam logic [10:0] C_LAST   = 11'(CARRIER_DIV - 1);
    localparam logic [10:0] C_HALF   = 11'(CARRIER_DIV / 2);

    state_t      state;
    state_t      next_state;
    logic [22:0] state_cnt;
    logic [22:0] state_last;
    logic [22:0] period_cnt;
    logic [31:0] shift;
    logic [5:0]  bit_cnt;
    logic [10:0] carrier_cnt;
    logic        at_last;
    logic        gap_end;
    logic        mark_now;
    logic        mark_next;

    function automatic logic is_mark(input state_t s);
        return (s == LEAD_L) || (s == BIT_L) || (s == STOP_L) ||
               (s == REP_L)  || (s == REP_STOP);
    endfunction

    assign mark_now  = is_mark(state);
    assign mark_next = is_mark(next_state);
    assign at_last   = (state_cnt == state_last);
    assign gap_end   = (state == GAP) && (period_cnt == P_LAST);

    assign busy   = (state != IDLE);
    assign ir_out = ~mark_now;
    assign ir_led = mark_now && (carrier_cnt < C_HALF);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Final count of the current state; a data space depends on the bit in flight.
    always_comb begin
        state_last = D_MARK;
        case (state)
            LEAD_L:  state_last = D_LEAD_L;
            REP_L:   state_last = D_LEAD_L;
            LEAD_H:  state_last = D_LEAD_H;
            REP_H:   state_last = D_REP_H;
            BIT_H:   state_last = shift[0] ? D_ONE_H : D_ZERO_H;
            default: state_last = D_MARK;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start)   next_state = LEAD_L;
            LEAD_L:   if (at_last) next_state = LEAD_H;
            LEAD_H:   if (at_last) next_state = BIT_L;
            BIT_L:    if (at_last) next_state = BIT_H;
            BIT_H:    if (at_last) next_state = (bit_cnt == 6'd31) ? STOP_L : BIT_L;
            STOP_L:   if (at_last) next_state = GAP;
            GAP:      if (gap_end) next_state = hold ? REP_L : IDLE;
            REP_L:    if (at_last) next_state = REP_H;
            REP_H:    if (at_last) next_state = REP_STOP;
            REP_STOP: if (at_last) next_state = GAP;
            default:  next_state = IDLE;
        endcase
    end

    // No state ever transitions to itself, so a state change always restarts the
    // in-state count; the period count restarts at frame start and each repeat.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_cnt   <= '0;
            period_cnt  <= '0;
            carrier_cnt <= '0;
            done        <= 1'b0;
        end else begin
            state_cnt <= (next_state != state) ? 23'd0 : state_cnt + 23'd1;

            if (state == IDLE) begin
                period_cnt <= '0;
            end else if (next_state == REP_L && state != REP_L) begin
                period_cnt <= '0;
            end else begin
                period_cnt <= period_cnt + 23'd1;
            end

            if (mark_next && !mark_now) begin
                carrier_cnt <= '0;
            end else if (mark_now && carrier_cnt != C_LAST) begin
                carrier_cnt <= carrier_cnt + 11'd1;
            end else begin
                carrier_cnt <= '0;
            end

            done <= gap_end && !hold;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            shift   <= '0;
            bit_cnt <= '0;
        end else if (state == IDLE && start) begin
            shift   <= {~data, data, ~addr, addr};
            bit_cnt <= '0;
        end else if (state == BIT_H && at_last) begin
            shift   <= {1'b0, shift[31:1]};
            bit_cnt <= bit_cnt + 6'd1;
        end
    end

endmodule

// File: tb/tb_nec_ir_tx.sv
// Bench for nec_ir_tx with shortened timings: per-cycle comparison against a
// segment-list waveform model, plus pulse-width decoding of the produced frame.
module tb_nec_ir_tx;

    localparam int T_LEAD_L = 40;
    localparam int T_LEAD_H = 20;
    localparam int T_REP_H  = 10;
    localparam int T_MARK   = 4;
    localparam int T_ONE_H  = 9;
    localparam int T_ZERO_H = 3;
    localparam int T_PERIOD = 600;
    localparam int CDIV     = 10;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       start;
    logic       hold;
    logic [7:0] addr;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic       ir_out;
    logic       ir_led;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         reps;
        int         glitch;
        bit         rnd_hold;
        bit         chain;
        int         exp_busy;
    } vec_t;

    vec_t vecs[6];

    bit exp_out[$];
    bit exp_led[$];
    bit exp_busy[$];
    bit exp_done[$];
    bit act_out[$];
    bit act_led[$];
    bit skip_start = 1'b0;

    nec_ir_tx #(
        .T_LEAD_L(T_LEAD_L), .T_LEAD_H(T_LEAD_H), .T_REP_H(T_REP_H),
        .T_MARK(T_MARK), .T_ONE_H(T_ONE_H), .T_ZERO_H(T_ZERO_H),
        .T_PERIOD(T_PERIOD), .CARRIER_DIV(CDIV)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .addr(addr),
        .data(data), .hold(hold), .busy(busy), .done(done),
        .ir_out(ir_out), .ir_led(ir_led)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [7:0] a, input logic [7:0] d, input logic h);
        start = st;
        addr  = a;
        data  = d;
        hold  = h;
    endtask

    // One baseband segment; the carrier restarts at the beginning of every mark.
    task automatic add_seg(input bit level, input int len);
        for (int p = 0; p < len; p++) begin
            exp_out.push_back(level);
            exp_led.push_back(!level && ((p % CDIV) < (CDIV / 2)));
            exp_busy.push_back(1'b1);
            exp_done.push_back(1'b0);
        end
    endtask

    task automatic pad_to(input int n);
        while (exp_out.size() < n) add_seg(1'b1, 1);
    endtask

    task automatic build_model(input logic [7:0] a, input logic [7:0] d, input int reps);
        logic [31:0] word;
        exp_out.delete(); exp_led.delete(); exp_busy.delete(); exp_done.delete();
        word = {~d, d, ~a, a};
        add_seg(1'b0, T_LEAD_L);
        add_seg(1'b1, T_LEAD_H);
        for (int i = 0; i < 32; i++) begin
            add_seg(1'b0, T_MARK);
            add_seg(1'b1, word[i] ? T_ONE_H : T_ZERO_H);
        end
        add_seg(1'b0, T_MARK);
        pad_to(T_PERIOD);
        for (int r = 0; r < reps; r++) begin
            add_seg(1'b0, T_LEAD_L);
            add_seg(1'b1, T_REP_H);
            add_seg(1'b0, T_MARK);
            pad_to((r + 2) * T_PERIOD);
        end
        exp_out.push_back(1'b1);
        exp_led.push_back(1'b0);
        exp_busy.push_back(1'b0);
        exp_done.push_back(1'b1);
    endtask

    task automatic run_frame(input int id, input logic [7:0] a, input logic [7:0] d,
                             input int reps, input int glitch, input bit rnd_hold,
                             input bit chain, input logic [7:0] na, input logic [7:0] nd,
                             input int want_busy);
        int n;
        int bad_out = 0, bad_led = 0, bad_busy = 0, bad_done = 0;
        int busy_cnt = 0;
        int idx;
        int w;
        logic [31:0] word = '0;
        build_model(a, d, reps);
        n = exp_out.size();
        if (!skip_start) begin
            applyStimulus(1'b1, a, d, 1'b0);
            @(posedge sys_clk); #1;
        end
        skip_start = 1'b0;
        act_out.delete();
        act_led.delete();
        for (int c = 0; c < n; c++) begin
            logic       h;
            logic       st;
            logic [7:0] ra;
            logic [7:0] rd;
            ra = 8'($urandom);
            rd = 8'($urandom);
            if (c % T_PERIOD == T_PERIOD - 1) h = (c / T_PERIOD) < reps;
            else if (rnd_hold)                h = 1'($urandom);
            else                              h = (c / T_PERIOD) < reps;
            st = (c == glitch) || (chain && c == n - 1);
            if (chain && c == n - 1) begin
                ra = na;
                rd = nd;
            end
            applyStimulus(st, ra, rd, h);
            @(negedge sys_clk);
            if (ir_out !== exp_out[c]) begin
                if (bad_out == 0) $display("[TB] frame %0d cycle %0d: ir_out %b want %b", id, c, ir_out, exp_out[c]);
                bad_out++;
            end
            if (ir_led !== exp_led[c]) begin
                if (bad_led == 0) $display("[TB] frame %0d cycle %0d: ir_led %b want %b", id, c, ir_led, exp_led[c]);
                bad_led++;
            end
            if (busy !== exp_busy[c]) begin
                if (bad_busy == 0) $display("[TB] frame %0d cycle %0d: busy %b want %b", id, c, busy, exp_busy[c]);
                bad_busy++;
            end
            if (done !== exp_done[c]) begin
                if (bad_done == 0) $display("[TB] frame %0d cycle %0d: done %b want %b", id, c, done, exp_done[c]);
                bad_done++;
            end
            busy_cnt += (busy === 1'b1) ? 1 : 0;
            act_out.push_back(ir_out === 1'b1);
            act_led.push_back(ir_led === 1'b1);
            @(posedge sys_clk); #1;
        end
        applyStimulus(1'b0, 8'($urandom), 8'($urandom), 1'b0);
        skip_start = chain;

        checkOutput($sformatf("frame %0d ir_out trace mismatches", id), bad_out, 0);
        checkOutput($sformatf("frame %0d ir_led trace mismatches", id), bad_led, 0);
        checkOutput($sformatf("frame %0d busy trace mismatches", id), bad_busy, 0);
        checkOutput($sformatf("frame %0d done trace mismatches", id), bad_done, 0);
        checkOutput($sformatf("frame %0d busy cycles", id), busy_cnt, want_busy);

        // Receiver-style decode: classify each space after a bit mark by its width.
        idx = T_LEAD_L + T_LEAD_H;
        for (int i = 0; i < 32; i++) begin
            idx += T_MARK;
            w = 0;
            while (idx < act_out.size() && act_out[idx]) begin
                w++;
                idx++;
            end
            word[i] = (w > (T_ONE_H + T_ZERO_H) / 2);
        end
        checkOutput($sformatf("frame %0d decoded addr", id), word[7:0], a);
        checkOutput($sformatf("frame %0d decoded data", id), word[23:16], d);
        checkOutput($sformatf("frame %0d decoded inverses", id), {word[31:24], word[15:8]}, {~d, ~a});
    endtask

    initial begin
        int hi_cnt;
        int rise1;
        int rise2;
        logic [7:0] ra;
        logic [7:0] rd;
        int reps;

        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        checkOutput("reset ir_out", ir_out, 1);
        checkOutput("reset ir_led", ir_led, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;

        vecs[0] = '{8'h99, 8'h22, 0, -1,  1'b0, 1'b0, 600};
        vecs[1] = '{8'h99, 8'h22, 1, -1,  1'b0, 1'b0, 1200};
        vecs[2] = '{8'h99, 8'h22, 0, 165, 1'b0, 1'b0, 600};
        vecs[3] = '{8'h00, 8'hFF, 2, 300, 1'b1, 1'b0, 1800};
        vecs[4] = '{8'hFF, 8'h00, 0, -1,  1'b1, 1'b1, 600};
        vecs[5] = '{8'h5A, 8'hA5, 1, 50,  1'b1, 1'b0, 1200};

        for (int i = 0; i < 6; i++) begin
            ra = (i < 5) ? vecs[i + 1].addr : 8'h00;
            rd = (i < 5) ? vecs[i + 1].data : 8'h00;
            $display("[TB] vector %0d addr=%02h data=%02h reps=%0d", i, vecs[i].addr, vecs[i].data, vecs[i].reps);
            run_frame(i, vecs[i].addr, vecs[i].data, vecs[i].reps, vecs[i].glitch,
                      vecs[i].rnd_hold, vecs[i].chain, ra, rd, vecs[i].exp_busy);
            if (i == 0) begin
                hi_cnt = 0;
                rise1 = -1;
                rise2 = -1;
                for (int c = 0; c < T_LEAD_L; c++) begin
                    if (act_led[c]) hi_cnt++;
                    if (act_led[c] && (c == 0 || !act_led[c - 1])) begin
                        if (rise1 < 0) rise1 = c;
                        else if (rise2 < 0) rise2 = c;
                    end
                end
                checkOutput("leader carrier high cycles", hi_cnt, (T_LEAD_L / CDIV) * (CDIV / 2));
                checkOutput("leader carrier period", rise2 - rise1, CDIV);
            end
            if (!vecs[i].chain) begin
                repeat (2) @(posedge sys_clk);
                #1;
            end
        end

        for (int k = 0; k < 4; k++) begin
            ra   = 8'($urandom);
            rd   = 8'($urandom);
            reps = $urandom_range(0, 2);
            run_frame(10 + k, ra, rd, reps, $urandom_range(1, 500), 1'b1, 1'b0,
                      8'h00, 8'h00, (reps + 1) * T_PERIOD);
            repeat (3) @(posedge sys_clk);
            #1;
        end

        // Reset during the leader mark: the carrier must drop without waiting for a clock.
        applyStimulus(1'b1, 8'h3C, 8'hC3, 1'b0);
        @(posedge sys_clk); #1;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (2) @(posedge sys_clk);
        #3;
        checkOutput("pre-reset ir_led in leader", ir_led, 1);
        sys_rst = 1'b1;
        #1;
        checkOutput("reset in LEAD_L ir_led", ir_led, 0);
        checkOutput("reset in LEAD_L ir_out", ir_out, 1);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;

        // Reset during the leader space.
        applyStimulus(1'b1, 8'h3C, 8'hC3, 1'b0);
        @(posedge sys_clk); #1;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (45) @(posedge sys_clk);
        #3;
        checkOutput("pre-reset busy in LEAD_H", busy, 1);
        sys_rst = 1'b1;
        #1;
        checkOutput("reset in LEAD_H ir_out", ir_out, 1);
        checkOutput("reset in LEAD_H ir_led", ir_led, 0);
        checkOutput("reset in LEAD_H busy", busy, 0);
        checkOutput("reset in LEAD_H done", done, 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        run_frame(20, 8'h3C, 8'hC3, 0, -1, 1'b0, 1'b0, 8'h00, 8'h00, T_PERIOD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
